// File: rtl/hdmi_tmds_pkg.sv
// Shared TMDS symbol constants and alignment FSM state type.
// Contents: the four control tokens, the 16-entry TERC4 code table
// (entry i encodes nibble i), both video guard-band codes and the
// alignment state enum. All codes are written q[9:0], q[0] first on the wire.
package hdmi_tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [15:0][9:0] TERC4_TABLE = {
    10'b1011000011, 10'b0101100011, 10'b1001110001, 10'b1010001110,
    10'b1011000110, 10'b0110011100, 10'b0100111001, 10'b1011001100,
    10'b0100111100, 10'b0110001110, 10'b0100011110, 10'b0101110001,
    10'b1011100010, 10'b1011100100, 10'b1001100011, 10'b1010011100
  };

  // Lanes 0 and 2 share one guard code, lane 1 uses its complement.
  localparam logic [9:0] GUARD_VIDEO_BR = 10'b1011001100;
  localparam logic [9:0] GUARD_VIDEO_G  = 10'b0100110011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

endpackage

// File: rtl/tmds_channel_receiver_if.sv
// Bus bundle of one TMDS lane receiver.
// master: drives tmds_raw (10 b unaligned word) and resync, observes results.
// slave : the receiver; consumes tmds_raw/resync, drives locked, bit_offset,
//         symbol and the decoded control/TERC4/guard/video fields.
interface tmds_channel_receiver_if;
  logic [9:0] tmds_raw;
  logic       resync;
  logic       locked;
  logic [3:0] bit_offset;
  logic [9:0] symbol;
  logic       is_control;
  logic [1:0] control_data;
  logic       is_terc4;
  logic [3:0] terc4_data;
  logic       is_video_guard;
  logic [7:0] video_data;

  modport master (
    output tmds_raw, resync,
    input  locked, bit_offset, symbol, is_control, control_data,
           is_terc4, terc4_data, is_video_guard, video_data
  );

  modport slave (
    input  tmds_raw, resync,
    output locked, bit_offset, symbol, is_control, control_data,
           is_terc4, terc4_data, is_video_guard, video_data
  );
endinterface

// File: rtl/tmds_symbol_decoder.sv
// Purely combinational decode of one aligned 10-bit TMDS symbol.
// Parameter CN: lane number, selects the video guard-band code.
// Ports: symbol (in 10) -> is_control/control_data, is_terc4/terc4_data,
//        is_video_guard, video_data (8b/10b decode, always produced).
module tmds_symbol_decoder
  import hdmi_tmds_pkg::*;
#(
  parameter int unsigned CN = 0
) (
  input  logic [9:0] symbol,
  output logic       is_control,
  output logic [1:0] control_data,
  output logic       is_terc4,
  output logic [3:0] terc4_data,
  output logic       is_video_guard,
  output logic [7:0] video_data
);

  localparam logic [9:0] GUARD_CODE = (CN == 1) ? GUARD_VIDEO_G : GUARD_VIDEO_BR;

  logic [7:0] q_inv;
  logic [7:0] q_xor;

  always_comb begin
    is_control   = 1'b0;
    control_data = '0;
    case (symbol)
      CTRL_TOKEN_00: begin is_control = 1'b1; control_data = 2'b00; end
      CTRL_TOKEN_01: begin is_control = 1'b1; control_data = 2'b01; end
      CTRL_TOKEN_10: begin is_control = 1'b1; control_data = 2'b10; end
      CTRL_TOKEN_11: begin is_control = 1'b1; control_data = 2'b11; end
      default: ;
    endcase
  end

  always_comb begin
    is_terc4   = 1'b0;
    terc4_data = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (symbol == TERC4_TABLE[4'(i)]) begin
        is_terc4   = 1'b1;
        terc4_data = 4'(i);
      end
    end
  end

  assign is_video_guard = (symbol == GUARD_CODE);

  // Each data bit i>0 is recovered from the pair (q'[i], q'[i-1]).
  assign q_inv = symbol[9] ? ~symbol[7:0] : symbol[7:0];
  assign q_xor = q_inv ^ {q_inv[6:0], 1'b0};
  assign video_data = symbol[8] ? {q_xor[7:1], q_inv[0]} : {~q_xor[7:1], q_inv[0]};

endmodule

// File: rtl/tmds_channel_receiver.sv
// One-lane TMDS sink: recovers symbol alignment from control tokens and
// decodes every aligned symbol.
// Parameters: CN (lane), CTRL_RUN (tokens to lock), SEARCH_CYCLES (cycles per
//   offset before slipping), LOSS_CYCLES (token-free cycles before unlock).
// Ports: clk_pixel, reset_n (async, active low), rx (slave modport: tmds_raw,
//   resync in; locked, bit_offset, symbol and decoded fields out).
// Optional macro TMDS_RX_STATS_EN adds lock_loss_count[7:0], a saturating
//   count of LOCKED exits.
// Latency: outputs appear two clocks after the tmds_raw word that completes them.
module tmds_channel_receiver
  import hdmi_tmds_pkg::*;
#(
  parameter int unsigned CN            = 0,
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SEARCH_CYCLES = 4096,
  parameter int unsigned LOSS_CYCLES   = 4096
) (
  input  logic clk_pixel,
  input  logic reset_n,
  tmds_channel_receiver_if.slave rx
`ifdef TMDS_RX_STATS_EN
  ,
  output logic [7:0] lock_loss_count
`endif
);

  localparam int unsigned SW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
  localparam int unsigned LW = (LOSS_CYCLES > 1) ? $clog2(LOSS_CYCLES) : 1;
  localparam int unsigned RW = $clog2(CTRL_RUN + 1);
  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_CYCLES - 1);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST    = RW'(CTRL_RUN - 1);

  align_state_t  state, state_next;
  logic [3:0]    offset, offset_next;
  logic [SW-1:0] search_timer, search_next;
  logic [LW-1:0] loss_timer, loss_next;
  logic [RW-1:0] run, run_next;
  logic          slip;

  logic [9:0]  prev_raw;
  logic [19:0] window;
  logic [9:0]  slice;
  logic [9:0]  s1;

  logic       dec_control;
  logic [1:0] dec_control_data;
  logic       dec_terc4;
  logic [3:0] dec_terc4_data;
  logic       dec_guard;
  logic [7:0] dec_video;

  assign window = {rx.tmds_raw, prev_raw};
  assign slice  = window[{1'b0, offset} +: 10];

  tmds_symbol_decoder #(.CN(CN)) u_dec (
    .symbol         (s1),
    .is_control     (dec_control),
    .control_data   (dec_control_data),
    .is_terc4       (dec_terc4),
    .terc4_data     (dec_terc4_data),
    .is_video_guard (dec_guard),
    .video_data     (dec_video)
  );

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      prev_raw     <= '0;
      s1           <= '0;
      state        <= SEARCH;
      offset       <= '0;
      search_timer <= '0;
      loss_timer   <= '0;
      run          <= '0;
    end else begin
      prev_raw     <= rx.tmds_raw;
      s1           <= slice;
      state        <= state_next;
      offset       <= offset_next;
      search_timer <= search_next;
      loss_timer   <= loss_next;
      run          <= run_next;
    end
  end

  always_comb begin
    state_next  = state;
    offset_next = offset;
    search_next = search_timer;
    loss_next   = loss_timer;
    run_next    = run;
    slip        = 1'b0;
    case (state)
      SEARCH: begin
        if (dec_control) begin
          state_next  = VERIFY;
          run_next    = RW'(1);
          search_next = '0;
        end else if (search_timer == SEARCH_LAST) begin
          slip        = 1'b1;
          search_next = '0;
        end else begin
          search_next = search_timer + 1'b1;
        end
      end
      VERIFY: begin
        if (dec_control) begin
          if (run == RUN_LAST) begin
            state_next = LOCKED;
            loss_next  = '0;
          end else begin
            run_next = run + 1'b1;
          end
        end else begin
          state_next  = SEARCH;
          slip        = 1'b1;
          search_next = '0;
        end
      end
      LOCKED: begin
        if (dec_control) begin
          loss_next = '0;
        end else if (loss_timer == LOSS_LAST) begin
          state_next  = SEARCH;
          slip        = 1'b1;
          search_next = '0;
        end else begin
          loss_next = loss_timer + 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
    // Applied last so it overrides any lock or loss decision above.
    if (rx.resync) begin
      state_next  = SEARCH;
      slip        = 1'b1;
      search_next = '0;
      loss_next   = '0;
      run_next    = '0;
    end
    if (slip) begin
      offset_next = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
    end
  end

  assign rx.locked     = (state == LOCKED);
  assign rx.bit_offset = offset;

  // Flags are qualified with the lock state being entered at the same edge,
  // so they line up with rx.locked.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rx.symbol         <= '0;
      rx.is_control     <= 1'b0;
      rx.control_data   <= '0;
      rx.is_terc4       <= 1'b0;
      rx.terc4_data     <= '0;
      rx.is_video_guard <= 1'b0;
      rx.video_data     <= '0;
    end else begin
      rx.symbol         <= s1;
      rx.is_control     <= dec_control && (state_next == LOCKED);
      rx.control_data   <= dec_control_data;
      rx.is_terc4       <= dec_terc4 && (state_next == LOCKED);
      rx.terc4_data     <= dec_terc4_data;
      rx.is_video_guard <= dec_guard && (state_next == LOCKED);
      rx.video_data     <= dec_video;
    end
  end

`ifdef TMDS_RX_STATS_EN
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_count <= '0;
    end else if ((state == LOCKED) && (state_next == SEARCH) && (lock_loss_count != 8'hFF)) begin
      lock_loss_count <= lock_loss_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_channel_receiver.sv
// Self-checking bench for tmds_channel_receiver (lane 0). A serial-stream
// model predicts every output each cycle; directed literal checks pin the
// model on the key scenarios. Honours TMDS_RX_STATS_EN.
module tb_tmds_channel_receiver;

  localparam int unsigned CN_P   = 0;
  localparam int unsigned RUN_P  = 8;
  localparam int unsigned SRCH_P = 8;
  localparam int unsigned LOSS_P = 16;

  localparam logic [9:0] TOK0  = 10'b1101010100;
  localparam logic [9:0] VID_A = 10'b0100000000;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  tmds_channel_receiver_if bus ();

`ifdef TMDS_RX_STATS_EN
  logic [7:0] lock_loss_count;
`endif

  tmds_channel_receiver #(
    .CN(CN_P), .CTRL_RUN(RUN_P), .SEARCH_CYCLES(SRCH_P), .LOSS_CYCLES(LOSS_P)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .rx        (bus)
`ifdef TMDS_RX_STATS_EN
    ,
    .lock_loss_count (lock_loss_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0] t4_tab [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  function automatic logic [2:0] m_ctrl(input logic [9:0] s);
    case (s)
      10'b1101010100: return 3'b100;
      10'b0010101011: return 3'b101;
      10'b0101010100: return 3'b110;
      10'b1010101011: return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  function automatic logic [4:0] m_terc4(input logic [9:0] s);
    for (int k = 0; k < 16; k++)
      if (t4_tab[k] == s) return {1'b1, 4'(k)};
    return 5'd0;
  endfunction

  function automatic logic [7:0] m_video(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int k = 1; k < 8; k++) d[k] = (q[k] ^ q[k-1]) ^ ~s[8];
    return d;
  endfunction

  // mode: 0 hunting, 1 confirming, 2 aligned
  int m_mode, m_off, m_idle, m_streak, m_miss, m_lost;
  logic [9:0] m_prev, m_s1, m_slice;
  logic [19:0] m_win;
  logic [2:0]  m_c;
  logic [4:0]  m_t;
  logic        e_locked, e_ctl, e_t4, e_guard;
  logic [1:0]  e_cd;
  logic [3:0]  e_off, e_td;
  logic [9:0]  e_sym;
  logic [7:0]  e_vid;

  task automatic m_next_offset();
    m_off  = (m_off + 1) % 10;
    m_idle = 0;
  endtask

  always @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_off = 0; m_idle = 0; m_streak = 0; m_miss = 0; m_lost = 0;
      m_prev = '0; m_s1 = '0;
      e_locked = 0; e_ctl = 0; e_t4 = 0; e_guard = 0;
      e_cd = 0; e_off = 0; e_td = 0; e_sym = 0; e_vid = 0;
    end else begin
      m_win   = {bus.tmds_raw, m_prev};
      m_slice = m_win[m_off +: 10];
      m_c = m_ctrl(m_s1);
      if (bus.resync) begin
        if (m_mode == 2) m_lost++;
        m_mode = 0; m_streak = 0; m_miss = 0;
        m_next_offset();
      end else if (m_mode == 0) begin
        if (m_c[2]) begin
          m_mode = 1; m_streak = 1; m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == SRCH_P) m_next_offset();
        end
      end else if (m_mode == 1) begin
        if (m_c[2]) begin
          m_streak++;
          if (m_streak == RUN_P) begin m_mode = 2; m_miss = 0; end
        end else begin
          m_mode = 0; m_next_offset();
        end
      end else begin
        if (m_c[2]) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == LOSS_P) begin m_mode = 0; m_lost++; m_next_offset(); end
        end
      end
      m_t      = m_terc4(m_s1);
      e_locked = (m_mode == 2);
      e_off    = 4'(m_off);
      e_sym    = m_s1;
      e_ctl    = m_c[2] && e_locked;
      e_cd     = m_c[1:0];
      e_t4     = m_t[4] && e_locked;
      e_td     = m_t[3:0];
      e_guard  = (m_s1 == ((CN_P == 1) ? 10'b0100110011 : 10'b1011001100)) && e_locked;
      e_vid    = m_video(m_s1);
      m_s1     = m_slice;
      m_prev   = bus.tmds_raw;
    end
  end

  always @(negedge clk_pixel) begin
    check("symbol", bus.symbol, e_sym);
    check("locked", bus.locked, e_locked);
    check("bit_offset", bus.bit_offset, e_off);
    check("is_control", bus.is_control, e_ctl);
    check("control_data", bus.control_data, e_cd);
    check("is_terc4", bus.is_terc4, e_t4);
    check("terc4_data", bus.terc4_data, e_td);
    check("is_video_guard", bus.is_video_guard, e_guard);
    check("video_data", bus.video_data, e_vid);
`ifdef TMDS_RX_STATS_EN
    check("lock_loss_count", lock_loss_count, (m_lost > 255) ? 255 : m_lost);
`endif
  end

  // ---------------- stimulus ----------------
  logic [9:0] last_sym = '0;

  // Symbols are placed on the serial stream skewed by 3 bits.
  task automatic send(input logic [9:0] sym, input logic rs);
    @(negedge clk_pixel);
    bus.tmds_raw = {sym[6:0], last_sym[9:7]};
    bus.resync   = rs;
    last_sym     = sym;
  endtask

  task automatic peek(input logic [9:0] sym);
    send(sym, 1'b0);
    send(TOK0, 1'b0);
    send(TOK0, 1'b0);
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic wait_lock();
    int n;
    n = 0;
    while (!bus.locked && n < 2000) begin
      send(TOK0, 1'b0);
      n++;
    end
    check("lock_wait", bus.locked, 1);
  endtask

  initial begin
    bus.tmds_raw = '0;
    bus.resync   = 1'b0;
    repeat (3) @(negedge clk_pixel);
    check("rst_locked", bus.locked, 0);
    check("rst_offset", bus.bit_offset, 0);
    check("rst_symbol", bus.symbol, 0);
    reset_n = 1'b1;

    wait_lock();
    check("lock_offset", bus.bit_offset, 3);
    check("lock_is_control", bus.is_control, 1);
    check("lock_control_data", bus.control_data, 0);
    check("lock_symbol", bus.symbol, TOK0);

    peek(VID_A);
    check("vid00_data", bus.video_data, 8'h00);
    check("vid00_ctl", bus.is_control, 0);
    peek(10'b1011111111);
    check("vidFE_data", bus.video_data, 8'hFE);
    check("vidFE_ctl", bus.is_control, 0);

    peek(10'b0100011110);
    check("terc4_5_flag", bus.is_terc4, 1);
    check("terc4_5_data", bus.terc4_data, 4'b0101);
    check("terc4_5_guard", bus.is_video_guard, 0);
    peek(10'b1011001100);
    check("terc4_8_flag", bus.is_terc4, 1);
    check("terc4_8_data", bus.terc4_data, 4'b1000);
    check("guard_flag", bus.is_video_guard, 1);
    peek(10'b1010101011);
    check("ctrl11_data", bus.control_data, 2'b11);

    repeat (LOSS_P - 2) send(VID_A, 1'b0);
    peek(VID_A);
    check("loss_minus1_locked", bus.locked, 1);
    repeat (LOSS_P - 1) send(VID_A, 1'b0);
    peek(VID_A);
    check("loss_locked", bus.locked, 0);
    check("loss_offset", bus.bit_offset, 4);
    check("loss_is_control", bus.is_control, 0);

    wait_lock();
    check("relock_offset", bus.bit_offset, 3);
    send(TOK0, 1'b1);
    send(TOK0, 1'b0);
    @(posedge clk_pixel);
    #1;
    check("resync_locked", bus.locked, 0);
    check("resync_offset", bus.bit_offset, 4);
`ifdef TMDS_RX_STATS_EN
    check("stats_two", lock_loss_count, 2);
    repeat (300) begin
      wait_lock();
      send(TOK0, 1'b1);
    end
    send(TOK0, 1'b0);
    send(TOK0, 1'b0);
    check("stats_saturate", lock_loss_count, 255);
`endif

    wait_lock();
    @(posedge clk_pixel);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_locked", bus.locked, 0);
    check("async_rst_offset", bus.bit_offset, 0);
    check("async_rst_symbol", bus.symbol, 0);
    check("async_rst_video", bus.video_data, 0);
    check("async_rst_ctl", bus.is_control, 0);
`ifdef TMDS_RX_STATS_EN
    check("async_rst_stats", lock_loss_count, 0);
`endif
    repeat (2) @(negedge clk_pixel);
    reset_n = 1'b1;
    repeat (4) send(TOK0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
